// File: rtl/fft_pkg.sv
// Shared constants, sample type and helpers for the streaming FFT datapath.
package fft_pkg;

  localparam int FFT_N_LOG2 = 8;
  localparam int FFT_DW     = 16;

  typedef struct packed {
    logic signed [FFT_DW-1:0] r;
    logic signed [FFT_DW-1:0] i;
  } cplx_t;

  typedef enum logic {
    RD_IDLE,
    RD_DRAIN
  } rd_state_t;

  function automatic logic [FFT_N_LOG2-1:0] bitrev(input logic [FFT_N_LOG2-1:0] x);
    logic [FFT_N_LOG2-1:0] y;
    for (int b = 0; b < FFT_N_LOG2; b++) y[b] = x[FFT_N_LOG2-1-b];
    return y;
  endfunction

endpackage

// File: rtl/fft_out_reorder_if.sv
// Sample stream into and out of the FFT output reorder stage.
interface fft_out_reorder_if #(
  parameter int N_LOG2 = fft_pkg::FFT_N_LOG2,
  parameter int DW     = fft_pkg::FFT_DW
);
  logic                     in_valid;
  logic                     in_start;
  logic signed [DW-1:0]     in_r;
  logic signed [DW-1:0]     in_i;
  logic                     out_valid;
  logic                     out_start;
  logic signed [DW-1:0]     out_r;
  logic signed [DW-1:0]     out_i;
  logic [N_LOG2-1:0]        out_idx;

  modport master (
    output in_valid, in_start, in_r, in_i,
    input  out_valid, out_start, out_r, out_i, out_idx
  );

  modport slave (
    input  in_valid, in_start, in_r, in_i,
    output out_valid, out_start, out_r, out_i, out_idx
  );
endinterface

// File: rtl/fft_reorder_ram.sv
// One reorder bank: simple dual-port RAM, synchronous write, registered read.
module fft_reorder_ram #(
  parameter int AW = 8,
  parameter int W  = 32
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [0:(1<<AW)-1];

  always_ff @(posedge CLK) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read register holds between reads so the stage output stays put when idle.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)    rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/fft_out_reorder.sv
// Bit-reversed to natural order reorder stage using a ping-pong pair of banks.
// Optional FFT_REORDER_ERR_EN adds the frame_err resync pulse output.
module fft_out_reorder
  import fft_pkg::*;
#(
  parameter int N_LOG2 = FFT_N_LOG2,
  parameter int DW     = FFT_DW
) (
  input  logic             CLK,
  input  logic             RST,
  fft_out_reorder_if.slave bus
`ifdef FFT_REORDER_ERR_EN
  ,
  output logic             frame_err
`endif
);

  logic [N_LOG2-1:0]       wr_cnt;
  logic                    wr_bank;
  logic [1:0]              bank_full;
  logic [1:0]              set_full;
  logic [1:0]              clr_full;
  logic                    accept;
  logic                    wr_done;
  logic [N_LOG2-1:0]       wr_addr;

  rd_state_t               state, state_nxt;
  logic                    rd_bank, rd_bank_nxt;
  logic [N_LOG2-1:0]       rd_cnt, rd_cnt_nxt;
  logic                    vld_p0;

  logic                    vld_p1;
  logic                    bank_p1;
  logic [N_LOG2-1:0]       idx_p1;
  logic [1:0][2*DW-1:0]    rdata;

  // A sample with no open frame (wr_cnt==0, no in_start) is dropped.
  always_comb begin
    accept   = bus.in_valid && (bus.in_start || (wr_cnt != '0));
    wr_done  = accept && !bus.in_start && (&wr_cnt);
    wr_addr  = bus.in_start ? '0 : bitrev(wr_cnt);
    set_full = '0;
    set_full[wr_bank] = wr_done;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_cnt  <= '0;
      wr_bank <= 1'b0;
    end else if (accept) begin
      wr_cnt <= bus.in_start ? N_LOG2'(1) : wr_cnt + 1'b1;
      if (wr_done) wr_bank <= ~wr_bank;
    end
  end

  // A set on the same edge as a clear wins, so a refilled bank is never lost.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) bank_full <= '0;
    else      bank_full <= (bank_full & ~clr_full) | set_full;
  end

  always_comb begin
    state_nxt   = state;
    rd_bank_nxt = rd_bank;
    rd_cnt_nxt  = rd_cnt;
    vld_p0      = 1'b0;
    clr_full    = '0;
    case (state)
      RD_IDLE: begin
        if (|bank_full) begin
          state_nxt   = RD_DRAIN;
          rd_cnt_nxt  = '0;
          rd_bank_nxt = (&bank_full) ? wr_bank : bank_full[1];
        end
      end
      RD_DRAIN: begin
        vld_p0     = 1'b1;
        rd_cnt_nxt = rd_cnt + 1'b1;
        if (&rd_cnt) begin
          clr_full[rd_bank] = 1'b1;
          if (bank_full[~rd_bank]) rd_bank_nxt = ~rd_bank;
          else                     state_nxt   = RD_IDLE;
        end
      end
      default: state_nxt = RD_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state   <= RD_IDLE;
      rd_bank <= 1'b0;
      rd_cnt  <= '0;
    end else begin
      state   <= state_nxt;
      rd_bank <= rd_bank_nxt;
      rd_cnt  <= rd_cnt_nxt;
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    fft_reorder_ram #(.AW(N_LOG2), .W(2*DW)) u_ram (
      .CLK   (CLK),
      .RST   (RST),
      .we    (accept && (wr_bank == 1'(b))),
      .waddr (wr_addr),
      .wdata ({bus.in_r, bus.in_i}),
      .re    (vld_p0 && (rd_bank == 1'(b))),
      .raddr (rd_cnt),
      .rdata (rdata[b])
    );
  end

  // p0 -> p1: address issued, registered RAM data appears
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      vld_p1  <= 1'b0;
      bank_p1 <= 1'b0;
      idx_p1  <= '0;
    end else begin
      vld_p1 <= vld_p0;
      if (vld_p0) begin
        bank_p1 <= rd_bank;
        idx_p1  <= rd_cnt;
      end
    end
  end

  assign bus.out_valid            = vld_p1;
  assign bus.out_idx              = idx_p1;
  assign bus.out_start            = vld_p1 && (idx_p1 == '0);
  assign {bus.out_r, bus.out_i}   = rdata[bank_p1];

`ifdef FFT_REORDER_ERR_EN
  logic resync;
  logic err_p1;

  assign resync = bus.in_valid && bus.in_start && (wr_cnt != '0);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) err_p1 <= 1'b0;
    else      err_p1 <= resync;
  end

  assign frame_err = err_p1;
`endif

endmodule

// File: tb/tb_fft_out_reorder.sv
// Directed bench for fft_out_reorder; builds with or without FFT_REORDER_ERR_EN.
module tb_fft_out_reorder;

  localparam int N = 256;
  localparam int OBS_MAX = 4096;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_err = 0;

  fft_out_reorder_if bus ();

`ifdef FFT_REORDER_ERR_EN
  logic frame_err;
  int   err_n = 0;
  int   err_cyc = -1;
`endif

  fft_out_reorder dut (
    .CLK       (CLK),
    .RST       (RST),
    .bus       (bus)
`ifdef FFT_REORDER_ERR_EN
    ,
    .frame_err (frame_err)
`endif
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  int          obs_n = 0;
  int          obs_cyc [OBS_MAX];
  logic        obs_st  [OBS_MAX];
  logic [7:0]  obs_idx [OBS_MAX];
  logic [15:0] obs_r   [OBS_MAX];
  logic [15:0] obs_i   [OBS_MAX];

  always @(negedge CLK) begin
    if (RST && bus.out_valid && obs_n < OBS_MAX) begin
      obs_cyc[obs_n] = cyc;
      obs_st[obs_n]  = bus.out_start;
      obs_idx[obs_n] = bus.out_idx;
      obs_r[obs_n]   = bus.out_r;
      obs_i[obs_n]   = bus.out_i;
      obs_n++;
    end
`ifdef FFT_REORDER_ERR_EN
    if (frame_err) begin
      err_n++;
      err_cyc = cyc;
    end
`endif
  end

  logic [15:0] sent_r [3][N];
  logic [15:0] sent_i [3][N];
  int          last_cyc;
  int          first_drive_cyc;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int tb_rev(input int k);
    int r = 0;
    for (int b = 0; b < 8; b++) if (k[b]) r |= (1 << (7 - b));
    return r;
  endfunction

  function automatic void gen(input int kind, input int f, input int j,
                              output logic [15:0] r, output logic [15:0] i);
    case (kind)
      0: begin r = 16'(j);            i = 16'(-j);         end
      1: begin r = 16'(f * 256 + j);  i = 16'(j * 5 - f);  end
      2: begin r = 16'(j * 3);        i = 16'(j + 7);      end
      3: begin r = 16'(j ^ 'h55);     i = 16'(-j - 1);     end
      4: begin r = ~16'(j);           i = 16'(j * 2);      end
      5: begin r = 16'(j + 1000);     i = 16'(j);          end
      default: begin r = 16'(16'h7000 + j); i = 16'h0bad; end
    endcase
  endfunction

  task automatic drive(input logic st, input logic [15:0] r, input logic [15:0] i);
    @(negedge CLK);
    bus.in_valid = 1'b1;
    bus.in_start = st;
    bus.in_r     = r;
    bus.in_i     = i;
    last_cyc     = cyc;
  endtask

  task automatic idle();
    @(negedge CLK);
    bus.in_valid = 1'b0;
    bus.in_start = 1'b0;
  endtask

  task automatic send_frame(input int f, input int kind, input bit gapped);
    logic [15:0] r, i;
    for (int j = 0; j < N; j++) begin
      if (gapped && j > 0) idle();
      gen(kind, f, j, r, i);
      sent_r[f][j] = r;
      sent_i[f][j] = i;
      drive(j == 0, r, i);
      if (j == 0) first_drive_cyc = cyc;
    end
  endtask

  task automatic check_frame(input string name, input int base, input int f, input int first);
    int e, j;
    for (int k = 0; k < N; k++) begin
      e = base + k;
      j = tb_rev(k);
      check($sformatf("%s bin%0d data", name, k),
            {23'd0, obs_st[e], obs_idx[e], obs_r[e], obs_i[e]},
            {23'd0, (k == 0), 8'(k), sent_r[f][j], sent_i[f][j]});
      check($sformatf("%s bin%0d cycle", name, k), 64'(obs_cyc[e]), 64'(first + k));
    end
  endtask

  initial begin
    int base;
    int first;
    logic [15:0] r, i;
`ifdef FFT_REORDER_ERR_EN
    int ebase;
`endif

    bus.in_valid = 1'b0;
    bus.in_start = 1'b0;
    bus.in_r     = '0;
    bus.in_i     = '0;

    // Reset state
    repeat (3) @(negedge CLK);
    check("reset valid/start", {bus.out_valid, bus.out_start}, 2'b00);
    check("reset data", {bus.out_r, bus.out_i}, 32'd0);
    check("reset idx", bus.out_idx, 8'd0);
`ifdef FFT_REORDER_ERR_EN
    check("reset frame_err", frame_err, 1'b0);
`endif
    RST = 1'b1;
    repeat (2) @(negedge CLK);

    // Single contiguous frame
    base = obs_n;
    send_frame(0, 0, 1'b0);
    idle();
    first = last_cyc + 3;
    repeat (N + 20) @(negedge CLK);
    check("single count", 64'(obs_n - base), 64'(N));
    check_frame("single", base, 0, first);

    // Three back-to-back frames
    base = obs_n;
    send_frame(0, 1, 1'b0);
    first = last_cyc + 3;
    send_frame(1, 1, 1'b0);
    send_frame(2, 1, 1'b0);
    idle();
    repeat (N + 20) @(negedge CLK);
    check("b2b count", 64'(obs_n - base), 64'(3 * N));
    for (int f = 0; f < 3; f++)
      check_frame($sformatf("b2b f%0d", f), base + f * N, f, first + f * N);

    // Gapped input at 50% duty
    base = obs_n;
    send_frame(0, 2, 1'b1);
    idle();
    first = last_cyc + 3;
    repeat (N + 20) @(negedge CLK);
    check("gapped count", 64'(obs_n - base), 64'(N));
    check_frame("gapped", base, 0, first);

    // Resync after 100 samples of a partial frame
    base = obs_n;
`ifdef FFT_REORDER_ERR_EN
    ebase = err_n;
`endif
    for (int j = 0; j < 100; j++) begin
      gen(6, 0, j, r, i);
      drive(j == 0, r, i);
    end
    send_frame(0, 3, 1'b0);
    idle();
    first = last_cyc + 3;
    repeat (N + 40) @(negedge CLK);
    check("resync count", 64'(obs_n - base), 64'(N));
    check_frame("resync", base, 0, first);
`ifdef FFT_REORDER_ERR_EN
    check("resync err pulses", 64'(err_n - ebase), 64'd1);
    check("resync err cycle", 64'(err_cyc), 64'(first_drive_cyc + 1));
`endif

    // Reset in the middle of a drain
    base = obs_n;
    send_frame(0, 5, 1'b0);
    idle();
    for (int t = 0; t < 400 && (obs_n - base) < 50; t++) @(negedge CLK);
    check("mid-drain reached", 64'((obs_n - base) >= 50), 64'd1);
    #2 RST = 1'b0;
    #1;
    check("mid-reset valid/start", {bus.out_valid, bus.out_start}, 2'b00);
    check("mid-reset data", {bus.out_r, bus.out_i}, 32'd0);
    check("mid-reset idx", bus.out_idx, 8'd0);
    repeat (3) @(negedge CLK);
    RST = 1'b1;
    repeat (2) @(negedge CLK);

    // Garbage without in_start, then a proper frame
    base = obs_n;
    for (int j = 0; j < 10; j++) drive(1'b0, 16'h1234, 16'h4321);
    send_frame(0, 4, 1'b0);
    idle();
    first = last_cyc + 3;
    repeat (N + 40) @(negedge CLK);
    check("post-reset count", 64'(obs_n - base), 64'(N));
    check_frame("post-reset", base, 0, first);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/fft_out_reorder.md
Name: fft_out_reorder

Overview:
- Output stage of the 256-point streaming FFT pipeline. Sits directly downstream of the last butterfly/twiddle stage.
- The pipeline emits each frame in bit-reversed bin order. This block buffers the frame in a ping-pong RAM and streams it out in natural order, bin 0 to bin N-1.
- Streaming only; there is no backpressure.

Parameters:
- N_LOG2, 8, log2 of frame length (N = 256).
- DW, 16, width of the real part and of the imaginary part.

Ports:
- CLK  in  1  system clock; all logic on posedge.
- RST  in  1  asynchronous, active-low reset.
- in_valid  in  1  sample present on in_r/in_i this cycle.
- in_start  in  1  qualifies the first sample of a frame; only meaningful with in_valid.
- in_r  in  DW  real part, bit-reversed order.
- in_i  in  DW  imaginary part, bit-reversed order.
- out_valid  out  1  out_r/out_i/out_idx valid.
- out_start  out  1  high with bin 0 of each output frame.
- out_r  out  DW  real part, natural order.
- out_i  out  DW  imaginary part, natural order.
- out_idx  out  N_LOG2  bin index of the current output.
- frame_err  out  1  one-cycle pulse on frame resync (REORDER_ERR_EN only).

Behaviour:
- Reset (RST low, async): out_valid=0, out_start=0, out_r=0, out_i=0, out_idx=0, frame_err=0. wr_cnt=0, wr_bank=0, both banks EMPTY, read FSM IDLE. RAM contents are don't-care.
- Storage: two banks, each 2^N_LOG2 x 2*DW. Write side and read side always use opposite banks.
- Write side:
  - Samples are accepted only when in_valid=1; gaps in in_valid are allowed.
  - Sample j is written at address bitrev(j), where j = wr_cnt and bitrev reverses all N_LOG2 bits.
  - wr_cnt counts 0..N-1. On the edge that accepts j=N-1: bank marked FULL, wr_bank toggles, wr_cnt wraps to 0.
  - Samples arriving while no frame is open: in_valid=1 with in_start=0 and wr_cnt=0 after reset or after a resync is dropped.
  - in_start=1 at wr_cnt=0 opens a frame.
- Resync: in_valid=1 and in_start=1 with wr_cnt!=0 discards the partial frame. The sample is written as j=0 of a new frame in the same bank, wr_cnt=1, and frame_err pulses.
- Write into the bank being drained: cannot occur in legal streaming, since read rate >= write rate. If it does occur, write-side priority holds: the bank is overwritten and the drain continues unchanged.
- Read FSM, states IDLE and DRAIN:
  - IDLE -> DRAIN on the cycle after any bank becomes FULL. rd_cnt=0, read bank = that bank.
  - DRAIN: reads address rd_cnt and increments it every cycle with no gaps.
  - At rd_cnt=N-1 the bank becomes EMPTY. If the other bank is already FULL, the FSM goes directly to DRAIN on it with no bubble; otherwise it returns to IDLE.
- Output timing:
  - RAM read is registered. out_r/out_i/out_idx are valid one cycle after the address is issued.
  - Latency: edge accepting sample N-1 at T; out_valid first high after edge T+2; last bin after edge T+N+1.
  - out_start=1 exactly when out_idx=0 and out_valid=1.
  - When out_valid=0, out_r/out_i hold their last value.
- Simultaneous write-complete and drain-complete on the same edge: the bank handoff happens with no lost frame.
- Reset mid-operation discards all buffered data; output stops immediately.

Optional Feature:
- Macro: FFT_REORDER_ERR_EN.
- Defined: frame_err port exists, and resync pulses it one cycle after the offending edge.
- Undefined: frame_err port is absent. Resync behaviour (discard the partial frame and restart) is unchanged.

Decomposition:
- Shared package fft_pkg holds: FFT_N_LOG2=8, FFT_DW=16, the cplx_t struct {r,i}, and the bitrev function.
- Sub-module fft_reorder_ram: one bank, simple dual-port, sync write, registered read. Instantiated twice.

Test Plan:
- Single frame: in_start at j=0, in_r=j, in_i=-j, contiguous 256 samples -> out_valid first high 2 cycles after the last input. out_r sequence = bitrev(k) for k=0..255. out_start only with out_idx=0.
- Back-to-back frames: 3 contiguous frames, frame f carrying in_r=f*256+j -> 768 contiguous out_valid cycles with no bubble. Every frame's values are correct.
- Gapped input: in_valid toggling 1,0 (50%) over one frame -> output is still a 256-cycle contiguous burst, starting 2 cycles after the last accepted sample.
- Resync: in_start reasserted at wr_cnt=100, then a full frame -> only one output frame, all values from the second frame. frame_err pulses once with the macro defined.
- Reset mid-drain: RST low at rd_cnt=50 -> outputs go to 0 asynchronously. After release, a new frame emerges correctly with no stale data.
- Pre-start garbage: 10 samples with in_valid=1, in_start=0 after reset, then a proper frame -> out_idx 0..255 carry only the proper frame's data.
